avalon_cmpt_cpu_debug_mem_arbiter: RTL and testbench
====================================================

# avalon_cmpt_cpu_debug_mem_arbiter

Shares the single-ported on-chip debug memory/register port (OCI RAM) between two requesters. One is the JTAG debug slave, whose single-cycle `take_action_ocimem_*` strobes and `jdo` payload arrive in the `clk` domain. The other is the CPU-side Avalon-MM debug slave. The block sits between the debug slave wrapper and the OCI memory. It buffers JTAG commands, which cannot be back-pressured, arbitrates with starvation protection, and returns JTAG read data toward `MonDReg`.

## Interface
Parameters:
- `ADDR_W`, 9: OCI word-address width.
- `RD_LAT`, 1: fixed OCI read latency in cycles, 1..4.
- `STARVE_MAX`, 4: consecutive JTAG grants allowed while Avalon waits.

Ports:
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `take_action_ocimem_a` in 1: JTAG cmd; set pointer = `jdo[ADDR_W-1:0]`, then read there.
- `take_action_ocimem_b` in 1: JTAG cmd; write `jdo[34:3]` at pointer, pointer++.
- `take_no_action_ocimem_a` in 1: JTAG cmd; read at pointer, pointer++.
- `jdo` in 38: JTAG payload, sampled in the strobe cycle.
- `jtag_rdata` out 32: JTAG read result, held until the next result.
- `jtag_rdata_valid` out 1: one-cycle pulse when `jtag_rdata` updates.
- `jtag_overflow` out 1: sticky; a JTAG command was dropped.
- `avs_address` in ADDR_W: Avalon address.
- `avs_read`, `avs_write` in 1: Avalon requests, held until accepted.
- `avs_writedata` in 32: Avalon write data.
- `avs_waitrequest` out 1: high while a request is not yet accepted.
- `avs_readdata` out 32: Avalon read data.
- `avs_readdatavalid` out 1: one-cycle pulse.
- `res_address` out ADDR_W: OCI address.
- `res_read`, `res_write` out 1: OCI access strobes, registered, at most one per cycle.
- `res_writedata` out 32: OCI write data.
- `res_readdata` in 32: OCI read data, valid `RD_LAT` cycles after `res_read`.

## Operation
- **JTAG capture.** Any JTAG strobe is enqueued into a 2-entry command FIFO as {op, address, data}.
  - The address is resolved at enqueue time from the pointer. `ocimem_a` uses `jdo[ADDR_W-1:0]`.
  - The pointer updates at enqueue: `ocimem_a` sets pointer = addr+1, and the others increment it. The pointer wraps modulo 2^ADDR_W.
- **Simultaneous strobes.** Only one is enqueued, in priority order `ocimem_b` > `ocimem_a` > `no_action_ocimem_a`. The others are dropped and `jtag_overflow` is set.
- **FIFO full.** A strobe arriving while the FIFO is full is dropped and `jtag_overflow` is set. The pointer is unchanged.
- **FSM states.**
  - IDLE: chooses a winner.
  - ISSUE: one cycle with `res_*` asserted.
  - WAIT_RD: counts `RD_LAT` cycles, then captures `res_readdata`.
  - A write returns ISSUE→IDLE. A read goes ISSUE→WAIT_RD→IDLE.
- **Arbitration in IDLE.**
  - JTAG wins if the FIFO is non-empty, unless the starvation counter equals `STARVE_MAX` and Avalon is requesting. In that case Avalon wins.
  - The counter increments on each JTAG grant while Avalon requests. It clears on any Avalon grant and whenever Avalon is idle.
- **Avalon handshake.** `avs_waitrequest` is low only in the ISSUE cycle of an Avalon grant. The request is accepted then. `avs_read` and `avs_write` both high is treated as a write.
- **Read return.** The captured word goes to `jtag_rdata`/`jtag_rdata_valid` or to `avs_readdata`/`avs_readdatavalid`, according to the owner recorded at grant.
- **Reset.**
  - All outputs are 0 except `avs_waitrequest`=1.
  - The FIFO is empty, the pointer and starvation counter are 0, and the state is IDLE.
  - Reset mid-read discards the access, and no valid pulse is produced.

## Timing
- JTAG strobe at cycle t: enqueued at t+1. If the FSM is IDLE with an empty FIFO, IDLE sees it at t+1 and ISSUE (`res_*` high) is t+2.
- Read issued at cycle s: data captured at s+`RD_LAT`. The valid pulse is at s+`RD_LAT`+1.
- A write takes 2 cycles IDLE→IDLE. A read takes `RD_LAT`+2.
- Avalon read presented at IDLE with no JTAG pending: accepted next cycle (ISSUE), `avs_readdatavalid` `RD_LAT`+1 cycles later.
- Only one OCI access is in flight. No pipelining.

## Structure
- Package `avalon_cmpt_cpu_debug_pkg` holds:
  - the command op enum {RD, WR};
  - the FSM state enum {IDLE, ISSUE, WAIT_RD};
  - the owner enum {OWN_JTAG, OWN_AVL};
  - the `jdo` field bit positions as constants.
- The command FIFO is a separate sub-module, `avalon_cmpt_cpu_debug_cmd_fifo`: depth 2, parameterised width, registered full/empty.

## Test plan
- **Pointer read and write-back:** `ocimem_a` with `jdo[8:0]`=0x010 and OCI[0x010]=0xDEADBEEF → `res_read` at t+2 with addr 0x010, `jtag_rdata`=0xDEADBEEF with one pulse at t+2+`RD_LAT`+1. A following `ocimem_b` with data 0x12345678 → write to 0x011.
- **FIFO overflow:** three `no_action_ocimem_a` strobes on consecutive cycles while an Avalon read is in WAIT_RD → two reads execute at 0x000 and 0x001, the third is dropped, and `jtag_overflow`=1 and stays set.
- **Starvation limit:** continuous JTAG traffic with `avs_read` held at 0x1F0, `STARVE_MAX`=4 → exactly 4 JTAG grants, then the Avalon grant with `avs_waitrequest` low for one cycle.
- **Simultaneous strobes:** `ocimem_b` and `no_action_ocimem_a` in the same cycle → one write only, and `jtag_overflow`=1.
- **Reset mid-read:** `reset` in the WAIT_RD cycle → no `jtag_rdata_valid`, all outputs at reset values next cycle, next command serviced normally.
- **Pointer wrap:** `ocimem_a` at 0x1FF followed by `no_action_ocimem_a` → the second read is at 0x000.

Source files
------------

// File: rtl/avalon_cmpt_cpu_debug_pkg.sv
// Shared types and jdo field positions for the OCI debug memory arbiter.
package avalon_cmpt_cpu_debug_pkg;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD
    } state_e;

    typedef enum logic {
        OWN_JTAG,
        OWN_AVL
    } owner_e;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned JDO_W        = 38;
    localparam int unsigned JDO_DATA_LSB = 3;
    localparam int unsigned JDO_DATA_MSB = 34;

endpackage

// File: rtl/avalon_cmpt_cpu_debug_mem_arbiter_if.sv
// Avalon-MM debug slave bus between the CPU side and the OCI arbiter.
interface avalon_cmpt_cpu_debug_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 9
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic              avs_waitrequest;
    logic [31:0]       avs_readdata;
    logic              avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_waitrequest, avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/avalon_cmpt_cpu_debug_cmd_fifo.sv
// Two-entry command FIFO with registered full/empty flags.
module avalon_cmpt_cpu_debug_cmd_fifo #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [0:1];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 2'd1;
        end else if (!do_push && do_pop) begin
            count_next = count - 2'd1;
        end
    end

    // Entry storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, count and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count_next;
            full  <= (count_next == 2'd2);
            empty <= (count_next == 2'd0);
        end
    end
endmodule

// File: rtl/avalon_cmpt_cpu_debug_mem_arbiter.sv
// Arbitrates the single OCI RAM port between buffered JTAG commands and the
// CPU-side Avalon slave, with starvation protection for the Avalon side.
module avalon_cmpt_cpu_debug_mem_arbiter
    import avalon_cmpt_cpu_debug_pkg::*;
#(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    output logic [31:0]       jtag_rdata,
    output logic              jtag_rdata_valid,
    output logic              jtag_overflow,
    avalon_cmpt_cpu_debug_mem_arbiter_if.slave avs,
    output logic [ADDR_W-1:0] res_address,
    output logic              res_read,
    output logic              res_write,
    output logic [31:0]       res_writedata,
    input  logic [31:0]       res_readdata
);
    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);
    localparam int unsigned SC_W  = $clog2(STARVE_MAX + 1) + 1;
    localparam logic [SC_W-1:0] STARVE_END = SC_W'(STARVE_MAX);
    localparam logic [2:0]      LAT_END    = 3'(RD_LAT);

    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;
    cmd_t              in_cmd;
    cmd_t              out_cmd;
    logic              any_strobe;
    logic              multi_strobe;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              avl_req;
    logic              jtag_win;
    state_e            state;
    owner_e            owner;
    logic              acc_rd;
    logic [2:0]        lat_cnt;
    logic [SC_W-1:0]   starve_cnt;
    logic              unused_jdo;

    assign unused_jdo   = ^jdo[37:35];
    assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign multi_strobe = (take_action_ocimem_a & take_action_ocimem_b) |
                          (take_action_ocimem_a & take_no_action_ocimem_a) |
                          (take_action_ocimem_b & take_no_action_ocimem_a);
    assign fifo_push    = any_strobe && !fifo_full;
    assign avl_req      = avs.avs_read | avs.avs_write;
    assign jtag_win     = !fifo_empty && !((starve_cnt == STARVE_END) && avl_req);
    assign fifo_pop     = (state == IDLE) && jtag_win;

    // Resolve the highest-priority strobe into a command and the next pointer.
    always_comb begin
        in_cmd   = '0;
        ptr_next = ptr + 1'b1;
        if (take_action_ocimem_b) begin
            in_cmd.op   = WR;
            in_cmd.addr = ptr;
            in_cmd.data = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
        end else if (take_action_ocimem_a) begin
            in_cmd.op   = RD;
            in_cmd.addr = jdo[ADDR_W-1:0];
            ptr_next    = jdo[ADDR_W-1:0] + 1'b1;
        end else begin
            in_cmd.op   = RD;
            in_cmd.addr = ptr;
        end
    end

    avalon_cmpt_cpu_debug_cmd_fifo #(
        .WIDTH(CMD_W)
    ) u_cmd_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_data(in_cmd),
        .pop      (fifo_pop),
        .pop_data (out_cmd),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // JTAG pointer moves only when a command is actually enqueued; drops are sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr           <= '0;
            jtag_overflow <= 1'b0;
        end else begin
            if (fifo_push) ptr <= ptr_next;
            if (multi_strobe || (any_strobe && fifo_full)) jtag_overflow <= 1'b1;
        end
    end

    // Access FSM with registered OCI strobes and return paths.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            owner                 <= OWN_JTAG;
            acc_rd                <= 1'b0;
            lat_cnt               <= '0;
            starve_cnt            <= '0;
            res_address           <= '0;
            res_read              <= 1'b0;
            res_write             <= 1'b0;
            res_writedata         <= '0;
            jtag_rdata            <= '0;
            jtag_rdata_valid      <= 1'b0;
            avs.avs_waitrequest   <= 1'b1;
            avs.avs_readdata      <= '0;
            avs.avs_readdatavalid <= 1'b0;
        end else begin
            jtag_rdata_valid      <= 1'b0;
            avs.avs_readdatavalid <= 1'b0;
            if (!avl_req) starve_cnt <= '0;
            case (state)
                IDLE: begin
                    if (jtag_win) begin
                        res_address   <= out_cmd.addr;
                        res_writedata <= out_cmd.data;
                        res_read      <= (out_cmd.op == RD);
                        res_write     <= (out_cmd.op == WR);
                        acc_rd        <= (out_cmd.op == RD);
                        owner         <= OWN_JTAG;
                        state         <= ISSUE;
                        if (avl_req) starve_cnt <= starve_cnt + 1'b1;
                    end else if (avl_req) begin
                        // Read and write together is serviced as a write.
                        res_address         <= avs.avs_address;
                        res_writedata       <= avs.avs_writedata;
                        res_read            <= !avs.avs_write;
                        res_write           <= avs.avs_write;
                        acc_rd              <= !avs.avs_write;
                        owner               <= OWN_AVL;
                        avs.avs_waitrequest <= 1'b0;
                        starve_cnt          <= '0;
                        state               <= ISSUE;
                    end
                end
                ISSUE: begin
                    res_read            <= 1'b0;
                    res_write           <= 1'b0;
                    avs.avs_waitrequest <= 1'b1;
                    lat_cnt             <= 3'd1;
                    state               <= acc_rd ? WAIT_RD : IDLE;
                end
                WAIT_RD: begin
                    if (lat_cnt == LAT_END) begin
                        if (owner == OWN_JTAG) begin
                            jtag_rdata       <= res_readdata;
                            jtag_rdata_valid <= 1'b1;
                        end else begin
                            avs.avs_readdata      <= res_readdata;
                            avs.avs_readdatavalid <= 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_avalon_cmpt_cpu_debug_mem_arbiter.sv
// Scoreboard bench for the OCI debug memory arbiter.
`timescale 1ns/1ps
module tb_avalon_cmpt_cpu_debug_mem_arbiter;
    localparam int ADDR_W     = 9;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic [37:0] jdo = '0;
    logic [31:0] jtag_rdata;
    logic        jtag_rdata_valid;
    logic        jtag_overflow;
    logic [8:0]  res_address;
    logic        res_read;
    logic        res_write;
    logic [31:0] res_writedata;
    logic [31:0] res_readdata;

    avalon_cmpt_cpu_debug_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    avalon_cmpt_cpu_debug_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .RD_LAT    (RD_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .take_action_ocimem_a   (take_action_ocimem_a),
        .take_action_ocimem_b   (take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .jdo                    (jdo),
        .jtag_rdata             (jtag_rdata),
        .jtag_rdata_valid       (jtag_rdata_valid),
        .jtag_overflow          (jtag_overflow),
        .avs                    (bus),
        .res_address            (res_address),
        .res_read               (res_read),
        .res_write              (res_write),
        .res_writedata          (res_writedata),
        .res_readdata           (res_readdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Cycle counter used for latency expectations.
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        bit          avl;
        logic [8:0]  addr;
        logic [31:0] data;
        int          at;
    } acc_t;

    typedef struct {
        logic [31:0] data;
        int          at;
    } rd_t;

    acc_t exp_acc[$];
    rd_t  exp_jtag[$];
    rd_t  exp_avs[$];
    acc_t ea;
    rd_t  er;

    // OCI memory model: unwritten words hold fixed, hand-known patterns.
    logic [31:0] wmem [512];
    bit          written [512];
    logic [8:0]  pend_addr = '0;
    int          age = 0;

    function automatic logic [31:0] mem_word(input logic [8:0] a);
        if (written[a]) return wmem[a];
        if (a == 9'h010) return 32'hDEAD_BEEF;
        return 32'hA500_0000 | 32'(a);
    endfunction

    // Memory writes and read-latency tracking.
    always @(posedge clk) begin
        if (res_write) begin
            wmem[res_address]    <= res_writedata;
            written[res_address] <= 1'b1;
        end
        if (res_read) begin
            pend_addr <= res_address;
            age       <= 1;
        end else if (age != 0 && age < RD_LAT) begin
            age <= age + 1;
        end else begin
            age <= 0;
        end
    end

    assign res_readdata = (age == RD_LAT) ? mem_word(pend_addr) : 32'hBAD0_BAD0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: compare every DUT-presented event against the scoreboard queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (res_read || res_write) begin
                if (exp_acc.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_access: got rd=%0b wr=%0b addr=%h expected no access", res_read, res_write, res_address);
                end else begin
                    ea = exp_acc.pop_front();
                    check("acc_write", 32'(res_write), 32'(ea.wr));
                    check("acc_read", 32'(res_read), 32'(!ea.wr));
                    check("acc_addr", 32'(res_address), 32'(ea.addr));
                    if (ea.wr) check("acc_wdata", res_writedata, ea.data);
                    check("acc_avl_owner", 32'(!bus.avs_waitrequest), 32'(ea.avl));
                    if (ea.at >= 0) check("acc_cycle", cyc, ea.at);
                end
            end else if (!bus.avs_waitrequest) begin
                checks++;
                errors++;
                $display("FAIL waitrequest_low: got low without OCI access expected high");
            end
            if (jtag_rdata_valid) begin
                if (exp_jtag.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_jtag_valid: got data %h expected no pulse", jtag_rdata);
                end else begin
                    er = exp_jtag.pop_front();
                    check("jtag_rdata", jtag_rdata, er.data);
                    if (er.at >= 0) check("jtag_valid_cycle", cyc, er.at);
                end
            end
            if (bus.avs_readdatavalid) begin
                if (exp_avs.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_avs_valid: got data %h expected no pulse", bus.avs_readdata);
                end else begin
                    er = exp_avs.pop_front();
                    check("avs_readdata", bus.avs_readdata, er.data);
                    if (er.at >= 0) check("avs_valid_cycle", cyc, er.at);
                end
            end
        end
    end

    task automatic push_acc(input bit wr, input bit avl, input logic [8:0] addr, input logic [31:0] data, input int at);
        acc_t e;
        e.wr = wr; e.avl = avl; e.addr = addr; e.data = data; e.at = at;
        exp_acc.push_back(e);
    endtask

    task automatic push_jtag(input logic [31:0] data, input int at);
        rd_t e;
        e.data = data; e.at = at;
        exp_jtag.push_back(e);
    endtask

    task automatic push_avs(input logic [31:0] data, input int at);
        rd_t e;
        e.data = data; e.at = at;
        exp_avs.push_back(e);
    endtask

    // One-cycle JTAG strobe; b uses jdo[34:3] as data, a uses jdo[8:0] as address.
    task automatic strobe(input bit a, input bit b, input bit n, input logic [8:0] addr, input logic [31:0] data);
        jdo = '0;
        if (b) jdo[34:3] = data;
        else   jdo[8:0]  = addr;
        take_action_ocimem_a    = a;
        take_action_ocimem_b    = b;
        take_no_action_ocimem_a = n;
        @(posedge clk); #1;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        jdo = '0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_acc.size() + exp_jtag.size() + exp_avs.size()) != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if ((exp_acc.size() + exp_jtag.size() + exp_avs.size()) != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_acc.size() + exp_jtag.size() + exp_avs.size());
            exp_acc.delete();
            exp_jtag.delete();
            exp_avs.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (bus.avs_waitrequest && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (bus.avs_waitrequest) begin
            checks++;
            errors++;
            $display("FAIL avs_accept_timeout: got waitrequest 1 expected 0");
        end
        @(posedge clk); #1;
        bus.avs_read  = 1'b0;
        bus.avs_write = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_res_read", 32'(res_read), 32'd0);
        check("rst_res_write", 32'(res_write), 32'd0);
        check("rst_res_address", 32'(res_address), 32'd0);
        check("rst_res_writedata", res_writedata, 32'd0);
        check("rst_jtag_rdata", jtag_rdata, 32'd0);
        check("rst_jtag_valid", 32'(jtag_rdata_valid), 32'd0);
        check("rst_jtag_overflow", 32'(jtag_overflow), 32'd0);
        check("rst_waitrequest", 32'(bus.avs_waitrequest), 32'd1);
        check("rst_avs_readdata", bus.avs_readdata, 32'd0);
        check("rst_avs_valid", 32'(bus.avs_readdatavalid), 32'd0);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_state();
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int t;
        int n;
        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;

        // Pointer read, write-back at pointer, read-back of the written word.
        do_reset(2);
        t = cyc;
        push_acc(1'b0, 1'b0, 9'h010, 32'h0, t + 2);
        push_jtag(32'hDEAD_BEEF, t + 2 + RD_LAT + 1);
        strobe(1'b1, 1'b0, 1'b0, 9'h010, 32'h0);
        drain();
        t = cyc;
        push_acc(1'b1, 1'b0, 9'h011, 32'h1234_5678, t + 2);
        strobe(1'b0, 1'b1, 1'b0, 9'h000, 32'h1234_5678);
        drain();
        push_acc(1'b0, 1'b0, 9'h011, 32'h0, -1);
        push_jtag(32'h1234_5678, -1);
        strobe(1'b1, 1'b0, 1'b0, 9'h011, 32'h0);
        drain();
        check("overflow_clear", 32'(jtag_overflow), 32'd0);

        // FIFO overflow while an Avalon read occupies the port.
        do_reset(2);
        push_acc(1'b0, 1'b1, 9'h020, 32'h0, -1);
        push_avs(32'hA500_0020, -1);
        push_acc(1'b0, 1'b0, 9'h000, 32'h0, -1);
        push_acc(1'b0, 1'b0, 9'h001, 32'h0, -1);
        push_jtag(32'hA500_0000, -1);
        push_jtag(32'hA500_0001, -1);
        bus.avs_address = 9'h020;
        bus.avs_read    = 1'b1;
        wait_accept();
        strobe(1'b0, 1'b0, 1'b1, 9'h000, 32'h0);
        strobe(1'b0, 1'b0, 1'b1, 9'h000, 32'h0);
        strobe(1'b0, 1'b0, 1'b1, 9'h000, 32'h0);
        drain();
        check("overflow_set", 32'(jtag_overflow), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("overflow_sticky", 32'(jtag_overflow), 32'd1);
        push_acc(1'b0, 1'b0, 9'h002, 32'h0, -1);
        push_jtag(32'hA500_0002, -1);
        strobe(1'b0, 1'b0, 1'b1, 9'h000, 32'h0);
        drain();

        // Starvation limit: four JTAG grants, then Avalon, then remaining JTAG.
        do_reset(2);
        for (int k = 0; k < 4; k++) push_acc(1'b0, 1'b0, 9'(k), 32'h0, -1);
        push_acc(1'b0, 1'b1, 9'h1F0, 32'h0, -1);
        push_acc(1'b0, 1'b0, 9'h004, 32'h0, -1);
        push_acc(1'b0, 1'b0, 9'h005, 32'h0, -1);
        for (int k = 0; k < 6; k++) push_jtag(32'hA500_0000 | 32'(k), -1);
        push_avs(32'hA500_01F0, -1);
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    strobe(1'b0, 1'b0, 1'b1, 9'h000, 32'h0);
                    repeat (3) begin
                        @(posedge clk); #1;
                    end
                end
            end
            begin
                @(posedge clk); #1;
                bus.avs_address = 9'h1F0;
                bus.avs_read    = 1'b1;
                wait_accept();
            end
        join
        drain();
        check("starve_no_overflow", 32'(jtag_overflow), 32'd0);

        // Simultaneous strobes: only the write is enqueued.
        do_reset(2);
        push_acc(1'b1, 1'b0, 9'h000, 32'hCAFE_F00D, -1);
        strobe(1'b0, 1'b1, 1'b1, 9'h000, 32'hCAFE_F00D);
        drain();
        check("simul_overflow", 32'(jtag_overflow), 32'd1);
        push_acc(1'b0, 1'b0, 9'h000, 32'h0, -1);
        push_jtag(32'hCAFE_F00D, -1);
        strobe(1'b1, 1'b0, 1'b0, 9'h000, 32'h0);
        drain();

        // Reset during WAIT_RD discards the read.
        do_reset(2);
        push_acc(1'b0, 1'b0, 9'h030, 32'h0, -1);
        strobe(1'b1, 1'b0, 1'b0, 9'h030, 32'h0);
        n = 0;
        @(negedge clk);
        while (!res_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midrd_issue_seen", 32'(res_read), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_state();
        repeat (6) @(posedge clk);
        #1;
        push_acc(1'b0, 1'b0, 9'h031, 32'h0, -1);
        push_jtag(32'hA500_0031, -1);
        strobe(1'b1, 1'b0, 1'b0, 9'h031, 32'h0);
        drain();

        // Pointer wrap from 0x1FF to 0x000.
        do_reset(2);
        push_acc(1'b0, 1'b0, 9'h1FF, 32'h0, -1);
        push_acc(1'b0, 1'b0, 9'h000, 32'h0, -1);
        push_jtag(32'hA500_01FF, -1);
        push_jtag(32'hCAFE_F00D, -1);
        strobe(1'b1, 1'b0, 1'b0, 9'h1FF, 32'h0);
        strobe(1'b0, 1'b0, 1'b1, 9'h000, 32'h0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
